// File: rtl/dm_store_buffer_if.sv
// Store-request and memory-drain signals for dm_store_buffer.
// master = pipeline/memory side driving stores and acks, slave = the buffer itself.
interface dm_store_buffer_if #(
    parameter int PTR_W = 2
);
    logic             st_valid;
    logic             st_ready;
    logic [1:0]       st_op;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             mem_req;
    logic             mem_ack;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             busy;
    logic [PTR_W:0]   count;
    logic             misalign;
    logic [31:0]      bad_addr;

    modport master (
        output st_valid, st_op, st_addr, st_data, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, busy, count, misalign, bad_addr
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be, busy, count, misalign, bad_addr
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Store buffer: lane-aligns sb/sh/sw data, builds byte enables, queues entries toward data memory.
// Latency: push at edge N -> mem_req in cycle N+1 when empty. Backpressure: st_ready = !full only.
// Optional misaligned-store trap enabled by defining DM_MISALIGN_TRAP_EN.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    dm_store_buffer_if.slave sb
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [1:0]     OP_NONE  = 2'b00;
    localparam logic [1:0]     OP_SB    = 2'b01;
    localparam logic [1:0]     OP_SH    = 2'b10;
    localparam logic [1:0]     OP_SW    = 2'b11;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t           store_q [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             full;
    logic             is_misaligned;
    logic             push;
    logic             pop;

    always_comb begin
        new_entry.waddr = sb.st_addr[31:2];
        new_entry.wdata = sb.st_data;
        new_entry.be    = 4'b1111;
        case (sb.st_op)
            OP_SB: begin
                new_entry.wdata = {4{sb.st_data[7:0]}};
                new_entry.be    = 4'b0001 << sb.st_addr[1:0];
            end
            OP_SH: begin
                new_entry.wdata = {2{sb.st_data[15:0]}};
                new_entry.be    = sb.st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign full = (cnt == FULL_CNT);
    assign push = sb.st_valid && !full && (sb.st_op != OP_NONE) && !is_misaligned;
    // An ack while empty has nothing to retire.
    assign pop  = (cnt != '0) && sb.mem_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
        end else begin
            if (push) begin
                store_q[wr_ptr] <= new_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign head         = store_q[rd_ptr];
    assign sb.st_ready  = !full;
    assign sb.mem_req   = (cnt != '0);
    assign sb.mem_addr  = {head.waddr, 2'b00};
    assign sb.mem_wdata = head.wdata;
    assign sb.mem_be    = head.be;
    assign sb.busy      = (cnt != '0);
    assign sb.count     = cnt;

`ifdef DM_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic [31:0] bad_addr_q;

    assign is_misaligned = ((sb.st_op == OP_SH) && sb.st_addr[0]) ||
                           ((sb.st_op == OP_SW) && (sb.st_addr[1:0] != 2'b00));

    // Rejection is flagged regardless of st_ready; the store never enters the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            misalign_q <= sb.st_valid && is_misaligned;
            if (sb.st_valid && is_misaligned) bad_addr_q <= sb.st_addr;
        end
    end

    assign sb.misalign = misalign_q;
    assign sb.bad_addr = bad_addr_q;
`else
    assign is_misaligned = 1'b0;
    assign sb.misalign   = 1'b0;
    assign sb.bad_addr   = '0;
`endif
endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: stimulus queues expected memory writes, a monitor checks each drained entry.
module tb_dm_store_buffer;
    logic clk = 1'b0;
    logic reset;

    dm_store_buffer_if #(.PTR_W(2)) sbif ();

    dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [67:0] exp_q[$];

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drained entry is compared whenever a handshake will complete at the next edge.
    always @(negedge clk) begin
        if (!reset && sbif.mem_req && sbif.mem_ack) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got addr %h wdata %h be %b expected none",
                         sbif.mem_addr, sbif.mem_wdata, sbif.mem_be);
            end else begin
                chk("sb_entry", {sbif.mem_addr, sbif.mem_wdata, sbif.mem_be}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_be);
        sbif.st_valid = 1'b1;
        sbif.st_op    = op;
        sbif.st_addr  = addr;
        sbif.st_data  = data;
        exp_q.push_back({e_addr, e_wdata, e_be});
        tick();
        sbif.st_valid = 1'b0;
        sbif.st_op    = 2'b00;
    endtask

    task automatic drain(input string name);
        int k = 0;
        sbif.mem_ack = 1'b1;
        while (sbif.count != 0 && k < 20) begin
            tick();
            k++;
        end
        sbif.mem_ack = 1'b0;
        chk(name, 68'(sbif.count), 68'd0);
        chk({name, "_sb_empty"}, 68'(exp_q.size()), 68'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        sbif.st_valid = 1'b0;
        sbif.st_op    = 2'b00;
        sbif.st_addr  = '0;
        sbif.st_data  = '0;
        sbif.mem_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // 1: reset state, sb lane replication, one-cycle latency, empty-ack, op none
        chk("rst_count",    68'(sbif.count),     68'd0);
        chk("rst_ready",    68'(sbif.st_ready),  68'd1);
        chk("rst_mem_req",  68'(sbif.mem_req),   68'd0);
        chk("rst_mem_addr", 68'(sbif.mem_addr),  68'd0);
        chk("rst_wdata",    68'(sbif.mem_wdata), 68'd0);
        chk("rst_be",       68'(sbif.mem_be),    68'd0);
        chk("rst_busy",     68'(sbif.busy),      68'd0);
        chk("rst_misalign", 68'(sbif.misalign),  68'd0);
        chk("rst_bad_addr", 68'(sbif.bad_addr),  68'd0);

        sbif.mem_ack = 1'b1;
        tick();
        sbif.mem_ack = 1'b0;
        chk("empty_ack_count", 68'(sbif.count), 68'd0);

        sbif.st_valid = 1'b1;
        sbif.st_op    = 2'b00;
        sbif.st_addr  = 32'h44;
        tick();
        sbif.st_valid = 1'b0;
        chk("op_none_count", 68'(sbif.count),   68'd0);
        chk("op_none_req",   68'(sbif.mem_req), 68'd0);

        store(2'b01, 32'h13, 32'h0000_00AB, 32'h10, 32'hABAB_ABAB, 4'b1000);
        chk("sb_latency_req", 68'(sbif.mem_req), 68'd1);
        sbif.mem_ack = 1'b1;
        tick();
        sbif.mem_ack = 1'b0;
        chk("sb_busy_after", 68'(sbif.busy), 68'd0);

        // 2: sh upper half, sw verbatim
        store(2'b10, 32'h22, 32'h0000_1234, 32'h20, 32'h1234_1234, 4'b1100);
        store(2'b11, 32'h40, 32'hDEAD_BEEF, 32'h40, 32'hDEAD_BEEF, 4'b1111);
        chk("t2_count", 68'(sbif.count), 68'd2);
        drain("t2_drain");

        // 3: fill, hold off fifth, release one per cycle
        store(2'b01, 32'h201, 32'h0000_0011, 32'h200, 32'h1111_1111, 4'b0010);
        store(2'b10, 32'h300, 32'h0000_BEEF, 32'h300, 32'hBEEF_BEEF, 4'b0011);
        store(2'b11, 32'h404, 32'hCAFE_F00D, 32'h404, 32'hCAFE_F00D, 4'b1111);
        store(2'b01, 32'h503, 32'h0000_007F, 32'h500, 32'h7F7F_7F7F, 4'b1000);
        chk("full_count", 68'(sbif.count),    68'd4);
        chk("full_ready", 68'(sbif.st_ready), 68'd0);
        sbif.st_valid = 1'b1;
        sbif.st_op    = 2'b11;
        sbif.st_addr  = 32'h600;
        sbif.st_data  = 32'h600D_F00D;
        tick();
        chk("held_off_count", 68'(sbif.count), 68'd4);
        sbif.mem_ack = 1'b1;
        exp_q.push_back({32'h600, 32'h600D_F00D, 4'b1111});
        #1;
        chk("full_ready_with_ack", 68'(sbif.st_ready), 68'd0);
        tick();
        chk("pop_full_count", 68'(sbif.count),    68'd3);
        chk("pop_full_ready", 68'(sbif.st_ready), 68'd1);
        tick();
        sbif.st_valid = 1'b0;
        chk("retry_push_pop_count", 68'(sbif.count), 68'd3);
        for (int i = 2; i >= 0; i--) begin
            tick();
            chk("drain_count", 68'(sbif.count), 68'(i));
        end
        sbif.mem_ack = 1'b0;
        chk("t3_sb_empty", 68'(exp_q.size()), 68'd0);

        // 4: push and pop together at count 1
        store(2'b01, 32'h700, 32'h0000_0001, 32'h700, 32'h0101_0101, 4'b0001);
        sbif.st_valid = 1'b1;
        sbif.st_op    = 2'b10;
        sbif.st_addr  = 32'h802;
        sbif.st_data  = 32'h0000_5555;
        sbif.mem_ack  = 1'b1;
        exp_q.push_back({32'h800, 32'h5555_5555, 4'b1100});
        tick();
        sbif.st_valid = 1'b0;
        sbif.mem_ack  = 1'b0;
        chk("pp_count",    68'(sbif.count),    68'd1);
        chk("pp_req",      68'(sbif.mem_req),  68'd1);
        chk("pp_head",     68'(sbif.mem_addr), 68'h800);
        chk("pp_head_be",  68'(sbif.mem_be),   68'b1100);
        drain("t4_drain");

        // 5: async reset with three pending entries
        store(2'b11, 32'h900, 32'h0000_0900, 32'h900, 32'h0000_0900, 4'b1111);
        store(2'b11, 32'hA00, 32'h0000_0A00, 32'hA00, 32'h0000_0A00, 4'b1111);
        store(2'b11, 32'hB00, 32'h0000_0B00, 32'hB00, 32'h0000_0B00, 4'b1111);
        chk("pre_rst_count", 68'(sbif.count), 68'd3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_req",   68'(sbif.mem_req), 68'd0);
        chk("async_rst_count", 68'(sbif.count),   68'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_req",  68'(sbif.mem_req),  68'd0);
        chk("post_rst_addr", 68'(sbif.mem_addr), 68'd0);
        store(2'b01, 32'hC01, 32'h0000_009A, 32'hC00, 32'h9A9A_9A9A, 4'b0010);
        chk("post_rst_head", 68'(sbif.mem_addr), 68'hC00);
        drain("t5_drain");

        // 6: misaligned sw
`ifdef DM_MISALIGN_TRAP_EN
        sbif.st_valid = 1'b1;
        sbif.st_op    = 2'b11;
        sbif.st_addr  = 32'h102;
        sbif.st_data  = 32'h1357_9BDF;
        tick();
        sbif.st_valid = 1'b0;
        chk("trap_count",    68'(sbif.count),    68'd0);
        chk("trap_misalign", 68'(sbif.misalign), 68'd1);
        chk("trap_bad_addr", 68'(sbif.bad_addr), 68'h102);
        tick();
        chk("trap_pulse_end", 68'(sbif.misalign), 68'd0);
`else
        store(2'b11, 32'h102, 32'h1357_9BDF, 32'h100, 32'h1357_9BDF, 4'b1111);
        chk("noTrap_count",    68'(sbif.count),    68'd1);
        chk("noTrap_misalign", 68'(sbif.misalign), 68'd0);
        drain("t6_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
